// File: rtl/mem_arbiter_if.sv
// Handshake and RAM-command bundle between two requesters, the arbiter and a registered-read RAM.
// The arbiter connects through the slave modport; requesters and the RAM side use master.
interface mem_arbiter_if #(
  parameter int WIDTH        = 16,
  parameter int RAM_adr_BITS = 16
);
  logic                    a_req, b_req;
  logic                    a_we, b_we;
  logic [RAM_adr_BITS-1:0] a_adr, b_adr;
  logic [WIDTH-1:0]        a_wdata, b_wdata;
  logic                    a_gnt, b_gnt;
  logic                    a_rvalid, b_rvalid;
  logic [WIDTH-1:0]        a_rdata, b_rdata;
  logic                    mem_en, mem_we;
  logic [RAM_adr_BITS-1:0] mem_adr;
  logic [WIDTH-1:0]        mem_wdata;
  logic [WIDTH-1:0]        mem_rdata;

  modport slave (
    input  a_req, a_we, a_adr, a_wdata,
    input  b_req, b_we, b_adr, b_wdata,
    input  mem_rdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_en, mem_we, mem_adr, mem_wdata
  );

  modport master (
    output a_req, a_we, a_adr, a_wdata,
    output b_req, b_we, b_adr, b_wdata,
    output mem_rdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_en, mem_we, mem_adr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM with one-cycle registered read data.
// Default build is fixed priority (A wins); define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
  parameter int WIDTH        = 16,
  parameter int RAM_adr_BITS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus
);

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

  logic                    a_elig, b_elig, grant_a, grant_b;
  logic                    mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [RAM_adr_BITS-1:0] mem_adr_q, mem_adr_d;
  logic [WIDTH-1:0]        mem_wdata_q, mem_wdata_d;
  logic                    a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                    rd1_q, rd1_d, rv_q, rv_d;
  owner_t                  own1_q, own1_d, own2_q, own2_d;
  owner_t                  last_q, last_d;

  always_comb begin
    // Own grant still showing masks a requester for one cycle, forcing alternation.
    a_elig  = bus.a_req & ~a_gnt_q;
    b_elig  = bus.b_req & ~b_gnt_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (a_elig && b_elig) begin
      grant_a = (last_q == OWN_B);
      grant_b = (last_q == OWN_A);
    end else begin
      grant_a = a_elig;
      grant_b = b_elig;
    end
`else
    grant_a = a_elig;
    grant_b = b_elig & ~a_elig;
`endif

    last_d      = last_q;
    mem_we_d    = 1'b0;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    own1_d      = OWN_A;
    if (grant_a) begin
      last_d      = OWN_A;
      mem_we_d    = bus.a_we;
      mem_adr_d   = bus.a_adr;
      mem_wdata_d = bus.a_wdata;
    end else if (grant_b) begin
      last_d      = OWN_B;
      mem_we_d    = bus.b_we;
      mem_adr_d   = bus.b_adr;
      mem_wdata_d = bus.b_wdata;
      own1_d      = OWN_B;
    end
    mem_en_d = grant_a | grant_b;
    a_gnt_d  = grant_a;
    b_gnt_d  = grant_b;
    rd1_d    = mem_en_d & ~mem_we_d;
    rv_d     = rd1_q;
    own2_d   = own1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      rd1_q       <= 1'b0;
      rv_q        <= 1'b0;
      own1_q      <= OWN_A;
      own2_q      <= OWN_A;
      last_q      <= OWN_B;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      rd1_q       <= rd1_d;
      rv_q        <= rv_d;
      own1_q      <= own1_d;
      own2_q      <= own2_d;
      last_q      <= last_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.a_gnt     = a_gnt_q;
  assign bus.b_gnt     = b_gnt_q;
  assign bus.a_rvalid  = rv_q & (own2_q == OWN_A);
  assign bus.b_rvalid  = rv_q & (own2_q == OWN_B);
  assign bus.a_rdata   = bus.mem_rdata;
  assign bus.b_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: registered-read RAM model, per-requester read-data scoreboards.
// Expectations follow the default fixed-priority build unless MEM_ARB_RR_EN is defined.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] ram [0:65535];
  logic [15:0] ram_rdata;

  mem_arbiter_if #(.WIDTH(16), .RAM_adr_BITS(16)) bus ();

  mem_arbiter #(.WIDTH(16), .RAM_adr_BITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: one-cycle registered read; preload held while in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      ram[16'h0010] <= 16'h1234;
      ram[16'h0030] <= 16'h5678;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_adr] <= bus.mem_wdata;
      else            ram_rdata        <= ram[bus.mem_adr];
    end
  end
  assign bus.mem_rdata = ram_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("gnt_exclusive", {31'd0, bus.a_gnt & bus.b_gnt}, 32'd0);
      chk("rvalid_exclusive", {31'd0, bus.a_rvalid & bus.b_rvalid}, 32'd0);
      if (bus.a_rvalid) begin
        if (qa.size() == 0) chk("a_rvalid_unexpected", {31'd0, bus.a_rvalid}, 32'd0);
        else                chk("a_rdata", {16'd0, bus.a_rdata}, {16'd0, qa.pop_front()});
      end
      if (bus.b_rvalid) begin
        if (qb.size() == 0) chk("b_rvalid_unexpected", {31'd0, bus.b_rvalid}, 32'd0);
        else                chk("b_rdata", {16'd0, bus.b_rdata}, {16'd0, qb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {26'd0, bus.mem_en, bus.mem_we, bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_adr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_adr = '0; bus.b_wdata = '0;
    #2;
    chk_idle("reset_outputs");
    chk("reset_adr_wdata", {bus.mem_adr, bus.mem_wdata}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Uncontended A read: grant next cycle, data the cycle after.
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_adr = 16'h0010;
    qa.push_back(16'h1234);
    tick();
    chk("t1_a_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd2);
    chk("t1_cmd", {14'd0, bus.mem_en, bus.mem_we, bus.mem_adr}, {14'd0, 2'b10, 16'h0010});
    bus.a_req = 1'b0;
    tick();
    chk("t1_a_rvalid", {30'd0, bus.a_rvalid, bus.a_gnt}, 32'd2);
    tick();

    // Fresh reset, then both requesters reading continuously.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_adr = 16'h0010;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_adr = 16'h0030;
    for (int i = 0; i < 3; i++) begin
      qa.push_back(16'h1234);
      qb.push_back(16'h5678);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t2_gnt_%0d", i), {30'd0, bus.a_gnt, bus.b_gnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
      chk($sformatf("t2_mem_en_%0d", i), {31'd0, bus.mem_en}, 32'd1);
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    tick(); tick();

    // A writes 0x00AA to 0x0020 while B reads it; B must see the new data.
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_adr = 16'h0020; bus.a_wdata = 16'h00AA;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_adr = 16'h0020;
    qb.push_back(16'h00AA);
    tick();
    chk("t3_a_wr_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd2);
    chk("t3_wr_cmd", {bus.mem_en, bus.mem_we, bus.mem_adr[13:0], bus.mem_wdata}, {2'b11, 14'h0020, 16'h00AA});
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_wdata = '0;
    tick();
    chk("t3_b_rd_gnt", {29'd0, bus.a_gnt, bus.b_gnt, bus.mem_we}, 32'd2);
    bus.b_req = 1'b0;
    tick();
    chk("t3_b_rvalid", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd1);

    // Uncontended B read.
    bus.b_req = 1'b1; bus.b_adr = 16'h0030;
    qb.push_back(16'h5678);
    tick();
    chk("t3b_b_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd1);
    bus.b_req = 1'b0;
    tick();
    chk("t3b_b_rvalid", {31'd0, bus.b_rvalid}, 32'd1);
    tick();

    // Reset between grant and rvalid drops the read.
    bus.a_req = 1'b1; bus.a_adr = 16'h0010;
    qa.push_back(16'h1234);
    tick();
    chk("t4_a_gnt", {31'd0, bus.a_gnt}, 32'd1);
    bus.a_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("t4_async_clear");
    chk("t4_adr_wdata_clear", {bus.mem_adr, bus.mem_wdata}, 32'd0);
    qa.delete();
    bus.a_req = 1'b1; bus.a_adr = 16'h0020;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    qa.push_back(16'h00AA);
    tick();
    chk("t4_first_arb", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd2);
    bus.a_req = 1'b0;
    tick();
    chk("t4_a_rvalid", {31'd0, bus.a_rvalid}, 32'd1);
    tick();

    // Idle: no enable, no pulses, address holds.
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5_idle_%0d", i), {25'd0, bus.mem_en, bus.mem_we, bus.a_gnt, bus.b_gnt,
                                        bus.a_rvalid, bus.b_rvalid, 1'b0}, 32'd0);
      chk($sformatf("t5_adr_hold_%0d", i), {16'd0, bus.mem_adr}, 32'h0020);
      tick();
    end

    // Contention after A was granted last: round-robin picks B, fixed priority picks A.
    bus.a_req = 1'b1; bus.a_adr = 16'h0010;
    bus.b_req = 1'b1; bus.b_adr = 16'h0030;
    qa.push_back(16'h1234);
    qb.push_back(16'h5678);
    tick();
`ifdef MEM_ARB_RR_EN
    chk("t6_first", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd1);
    bus.b_req = 1'b0;
    tick();
    chk("t6_second", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd2);
    bus.a_req = 1'b0;
`else
    chk("t6_first", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd2);
    bus.a_req = 1'b0;
    tick();
    chk("t6_second", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd1);
    bus.b_req = 1'b0;
`endif
    tick(); tick(); tick();

    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
